// File: rtl/seq_divider8b.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, with
// a busy/done handshake and a divide-by-zero flag.
module seq_divider8b #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   rem_reg;
  logic [WIDTH-1:0]   quo_reg;
  logic [WIDTH-1:0]   div_reg;
  logic [CNT_W-1:0]   count;

  logic [WIDTH:0]     r_shift;
  logic [WIDTH+1:0]   sum;
  logic               no_borrow;
  logic [WIDTH-1:0]   r_next;
  logic [WIDTH-1:0]   q_next;
  logic               last;
  logic               unused_trial_msb;

  // Trial subtraction as an add of the inverted divisor with carry-in 1;
  // the carry out of the WIDTH+1-bit sum means no borrow. The stored
  // remainder is always below the divisor, so WIDTH bits hold it.
  always_comb begin
    r_shift          = {rem_reg, quo_reg[WIDTH-1]};
    sum              = {1'b0, r_shift} + {1'b0, ~{1'b0, div_reg}}
                       + {{(WIDTH+1){1'b0}}, 1'b1};
    no_borrow        = sum[WIDTH+1];
    r_next           = no_borrow ? sum[WIDTH-1:0] : r_shift[WIDTH-1:0];
    q_next           = {quo_reg[WIDTH-2:0], no_borrow};
    last             = (count == CNT_W'(WIDTH - 1));
    unused_trial_msb = sum[WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rem_reg     <= '0;
      quo_reg     <= '0;
      div_reg     <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done  <= 1'b0;
          state <= IDLE;
          if (start) begin
            quo_reg     <= dividend;
            div_reg     <= divisor;
            rem_reg     <= '0;
            count       <= '0;
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              state       <= DONE;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              busy        <= 1'b0;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end

        RUN: begin
          rem_reg <= r_next;
          quo_reg <= q_next;
          count   <= count + 1'b1;
          // Results are published only on the final iteration.
          if (last) begin
            quotient  <= q_next;
            remainder <= r_next;
            state     <= DONE;
            done      <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider8b.sv
// Self-checking bench for seq_divider8b: directed scenarios plus a random
// sweep compared against plain / and % arithmetic.
module tb_seq_divider8b;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int tests;
  int fails;

  // Observations collected by run_op
  logic [7:0] obs_q, obs_r;
  logic       obs_dz, obs_dz_first, obs_qchanged, obs_timeout;
  int         obs_edges, obs_busy;

  seq_divider8b #(.WIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .quotient(quotient),
    .remainder(remainder),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Starts one operation from a point just after a rising edge and waits
  // (bounded) for done; optionally keeps start high with changing operands.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit hold);
    logic [7:0] q_before, r_before;
    q_before     = quotient;
    r_before     = remainder;
    dividend     = a;
    divisor      = b;
    start        = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    obs_edges    = 0;
    obs_busy     = 0;
    obs_qchanged = 1'b0;
    obs_timeout  = 1'b0;
    obs_dz_first = div_by_zero;
    while (!done) begin
      if (busy) obs_busy++;
      if (quotient !== q_before || remainder !== r_before) obs_qchanged = 1'b1;
      if (obs_edges >= 40) begin
        obs_timeout = 1'b1;
        break;
      end
      if (hold) begin
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
      end
      @(posedge clk); #1;
      obs_edges++;
    end
    start  = 1'b0;
    obs_q  = quotient;
    obs_r  = remainder;
    obs_dz = div_by_zero;
  endtask

  task automatic test_reset();
    tests++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 19'd0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got q=%0d r=%0d busy=%0b done=%0b dz=%0b expected all 0",
               quotient, remainder, busy, done, div_by_zero);
    end
  endtask

  task automatic test_basic();
    run_op(8'd200, 8'd7, 1'b0);
    tests++;
    if (obs_timeout || obs_edges != 8) begin
      fails++;
      $display("[TB] FAIL basic_latency: got %0d edges (timeout=%0b) expected 8", obs_edges, obs_timeout);
    end
    tests++;
    if (obs_q !== 8'd28 || obs_r !== 8'd4 || obs_dz !== 1'b0) begin
      fails++;
      $display("[TB] FAIL basic_result: got q=%0d r=%0d dz=%0b expected q=28 r=4 dz=0", obs_q, obs_r, obs_dz);
    end
    tests++;
    if (obs_busy != 8 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL basic_busy: got %0d busy cycles, busy_at_done=%0b expected 8 and 0", obs_busy, busy);
    end
    tests++;
    if (obs_qchanged) begin
      fails++;
      $display("[TB] FAIL basic_hold_during_run: got outputs changing before done expected stable");
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || quotient !== 8'd28 || remainder !== 8'd4) begin
      fails++;
      $display("[TB] FAIL basic_after_done: got done=%0b busy=%0b q=%0d r=%0d expected 0 0 28 4",
               done, busy, quotient, remainder);
    end
  endtask

  task automatic test_boundary();
    logic [7:0] as [6] = '{8'd255, 8'd5, 8'd0, 8'd255, 8'd1, 8'd128};
    logic [7:0] bs [6] = '{8'd1,   8'd9, 8'd3, 8'd255, 8'd255, 8'd2};
    for (int i = 0; i < 6; i++) begin
      run_op(as[i], bs[i], 1'b0);
      tests++;
      if (obs_timeout || obs_q !== as[i] / bs[i] || obs_r !== as[i] % bs[i] || obs_dz !== 1'b0) begin
        fails++;
        $display("[TB] FAIL boundary_%0d_%0d: got q=%0d r=%0d dz=%0b expected q=%0d r=%0d dz=0",
                 as[i], bs[i], obs_q, obs_r, obs_dz, as[i] / bs[i], as[i] % bs[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    run_op(8'h5A, 8'd0, 1'b0);
    tests++;
    if (obs_timeout || obs_edges != 0 || obs_busy != 0) begin
      fails++;
      $display("[TB] FAIL divzero_timing: got %0d extra edges, %0d busy cycles expected 0 and 0",
               obs_edges, obs_busy);
    end
    tests++;
    if (obs_q !== 8'hFF || obs_r !== 8'h5A || obs_dz !== 1'b1) begin
      fails++;
      $display("[TB] FAIL divzero_result: got q=%0h r=%0h dz=%0b expected q=ff r=5a dz=1", obs_q, obs_r, obs_dz);
    end
    @(posedge clk); #1;
    tests++;
    if (div_by_zero !== 1'b1 || done !== 1'b0 || quotient !== 8'hFF) begin
      fails++;
      $display("[TB] FAIL divzero_hold: got dz=%0b done=%0b q=%0h expected 1 0 ff", div_by_zero, done, quotient);
    end
    run_op(8'd100, 8'd10, 1'b0);
    tests++;
    if (obs_dz_first !== 1'b0 || obs_dz !== 1'b0 || obs_q !== 8'd10 || obs_r !== 8'd0) begin
      fails++;
      $display("[TB] FAIL divzero_clear: got dz_run=%0b dz=%0b q=%0d r=%0d expected 0 0 10 0",
               obs_dz_first, obs_dz, obs_q, obs_r);
    end
  endtask

  task automatic test_back_to_back();
    run_op(8'd100, 8'd10, 1'b1);
    tests++;
    if (obs_timeout || obs_edges != 8 || obs_q !== 8'd10 || obs_r !== 8'd0) begin
      fails++;
      $display("[TB] FAIL held_start: got q=%0d r=%0d after %0d edges expected q=10 r=0 after 8",
               obs_q, obs_r, obs_edges);
    end
    run_op(8'd99, 8'd8, 1'b0);
    tests++;
    if (obs_timeout || obs_edges != 8 || obs_q !== 8'd12 || obs_r !== 8'd3) begin
      fails++;
      $display("[TB] FAIL back_to_back: got q=%0d r=%0d after %0d edges expected q=12 r=3 after 8",
               obs_q, obs_r, obs_edges);
    end
  endtask

  task automatic test_reset_midrun();
    bit saw_done;
    dividend = 8'd200;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 19'd0) begin
      fails++;
      $display("[TB] FAIL midrun_abort: got q=%0d r=%0d busy=%0b done=%0b expected all 0",
               quotient, remainder, busy, done);
    end
    saw_done = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
      if (rst_n === 1'b0) rst_n = 1'b1;
    end
    tests++;
    if (saw_done) begin
      fails++;
      $display("[TB] FAIL midrun_no_done: got a done pulse expected none");
    end
    run_op(8'd200, 8'd7, 1'b0);
    tests++;
    if (obs_timeout || obs_edges != 8 || obs_q !== 8'd28 || obs_r !== 8'd4) begin
      fails++;
      $display("[TB] FAIL midrun_recover: got q=%0d r=%0d after %0d edges expected q=28 r=4 after 8",
               obs_q, obs_r, obs_edges);
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b, eq, er;
    bit         edz;
    int         elat, ebusy;
    for (int i = 0; i < 1500; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      if (b == 8'd0) begin
        eq = 8'hFF; er = a; edz = 1'b1; elat = 0; ebusy = 0;
      end else begin
        eq = a / b; er = a % b; edz = 1'b0; elat = 8; ebusy = 8;
      end
      run_op(a, b, 1'b0);
      tests++;
      if (obs_timeout || obs_q !== eq || obs_r !== er || obs_dz !== edz
          || obs_edges != elat || obs_busy != ebusy || obs_qchanged) begin
        fails++;
        $display("[TB] FAIL random_%0d_%0d: got q=%0d r=%0d dz=%0b lat=%0d busy=%0d chg=%0b expected q=%0d r=%0d dz=%0b lat=%0d busy=%0d chg=0",
                 a, b, obs_q, obs_r, obs_dz, obs_edges, obs_busy, obs_qchanged, eq, er, edz, elat, ebusy);
      end
      if (b != 8'd0) begin
        tests++;
        if (16'(obs_q) * 16'(b) + 16'(obs_r) != 16'(a) || obs_r >= b) begin
          fails++;
          $display("[TB] FAIL invariant_%0d_%0d: got q=%0d r=%0d expected q*b+r=a and r<b", a, b, obs_q, obs_r);
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_basic();
    test_boundary();
    test_div_zero();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
